// File: rtl/ay_bus_pkg.sv
// Shared types and constants for the dual-PSG bus sequencer.
package ay_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SEL_GAP,
    ADDR,
    ADDR_GAP,
    DATA,
    DATA_GAP
  } state_t;

  // {bdir, bc1} phase codes
  localparam logic [1:0] PH_ADDR  = 2'b11;
  localparam logic [1:0] PH_WRITE = 2'b10;
  localparam logic [1:0] PH_READ  = 2'b01;
  localparam logic [1:0] PH_IDLE  = 2'b00;

  localparam logic [6:0] CHIP_SEL_PREFIX = 7'b1111111;

  typedef struct packed {
    logic       chip;
    logic       write;
    logic [3:0] reg_num;
    logic [7:0] data;
  } req_t;

endpackage

// File: rtl/ay_req_fifo.sv
// Request queue: synchronous FIFO with async reset, push ignored when full, pop ignored when empty.
module ay_req_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk7,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk7) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk7 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ay_bus_sequencer.sv
// Bus initiator for a TurboSound PSG pair: turns queued register requests into
// stretched bdir/bc1/data phases, inserting a chip-select write on chip change.
module ay_bus_sequencer
  import ay_bus_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk7,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_chip,
  input  logic       req_write,
  input  logic [3:0] req_reg,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] bus_dout,
  input  logic [7:0] bus_din,
  input  logic       bus_oe_n,
  output logic       busy
);

  localparam int unsigned TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  state_t        state;
  req_t          req_in;
  req_t          head;
  req_t          work;
  logic          cur_chip;
  logic [TW-1:0] timer;
  logic          timer_done;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign req_in     = {req_chip, req_write, req_reg, req_data};
  assign req_ready  = ~fifo_full;
  assign push       = req_valid & ~fifo_full;
  assign pop        = (state == IDLE) & ~fifo_empty;
  assign busy       = (state != IDLE) | ~fifo_empty;
  assign timer_done = (timer == '0);

  ay_req_fifo #(
    .WIDTH($bits(req_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk7    (clk7),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (req_in),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk7 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      work      <= '0;
      cur_chip  <= 1'b1;
      timer     <= '0;
      bdir      <= 1'b0;
      bc1       <= 1'b0;
      bus_dout  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      // Timer free-runs down to zero; phase transitions below reload it.
      if (!timer_done) timer <= timer - 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            work         <= head;
            timer        <= HOLD_LOAD;
            {bdir, bc1}  <= PH_ADDR;
            if (head.chip != cur_chip) begin
              state    <= SEL;
              bus_dout <= {CHIP_SEL_PREFIX, head.chip};
            end else begin
              state    <= ADDR;
              bus_dout <= {4'h0, head.reg_num};
            end
          end
        end
        SEL: begin
          if (timer_done) begin
            state       <= SEL_GAP;
            {bdir, bc1} <= PH_IDLE;
            timer       <= GAP_LOAD;
            cur_chip    <= work.chip;
          end
        end
        SEL_GAP: begin
          if (timer_done) begin
            state       <= ADDR;
            {bdir, bc1} <= PH_ADDR;
            bus_dout    <= {4'h0, work.reg_num};
            timer       <= HOLD_LOAD;
          end
        end
        ADDR: begin
          if (timer_done) begin
            state       <= ADDR_GAP;
            {bdir, bc1} <= PH_IDLE;
            timer       <= GAP_LOAD;
          end
        end
        ADDR_GAP: begin
          if (timer_done) begin
            state <= DATA;
            timer <= HOLD_LOAD;
            if (work.write) begin
              {bdir, bc1} <= PH_WRITE;
              bus_dout    <= work.data;
            end else begin
              {bdir, bc1} <= PH_READ;
            end
          end
        end
        DATA: begin
          if (timer_done) begin
            state       <= DATA_GAP;
            {bdir, bc1} <= PH_IDLE;
            timer       <= GAP_LOAD;
            if (!work.write) begin
              rsp_valid <= 1'b1;
              rsp_data  <= bus_oe_n ? 8'hFF : bus_din;
            end
          end
        end
        DATA_GAP: begin
          if (timer_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ay_bus_sequencer.sv
// Scoreboard bench for ay_bus_sequencer: stimulus queues expected bus phases and
// read responses, a negedge monitor retires them as the DUT presents them.
module tb_ay_bus_sequencer;

  logic       clk7 = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_chip = 1'b1;
  logic       req_write = 1'b0;
  logic [3:0] req_reg = '0;
  logic [7:0] req_data = '0;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       bdir;
  logic       bc1;
  logic [7:0] bus_dout;
  logic [7:0] bus_din;
  logic       bus_oe_n;
  logic       busy;
  logic       psg_oe_dis = 1'b0;

  logic       r2_valid = 1'b0;
  logic       r2_chip = 1'b1;
  logic       r2_write = 1'b0;
  logic [3:0] r2_reg = '0;
  logic [7:0] r2_data = '0;
  logic       r2_ready;
  logic       r2_rsp_valid;
  logic [7:0] r2_rsp_data;
  logic       r2_bdir;
  logic       r2_bc1;
  logic [7:0] r2_dout;
  logic       r2_busy;

  always #5 clk7 = ~clk7;

  // PSG model: drives 0xA5 during the read phase, output enable can be forced off
  assign bus_oe_n = ~(bc1 & ~bdir) | psg_oe_dis;
  assign bus_din  = (bc1 & ~bdir) ? 8'hA5 : 8'h00;

  ay_bus_sequencer dut (
    .clk7(clk7), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_chip(req_chip),
    .req_write(req_write), .req_reg(req_reg), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bdir(bdir), .bc1(bc1), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_oe_n(bus_oe_n), .busy(busy)
  );

  ay_bus_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(2), .FIFO_DEPTH(4)) dut2 (
    .clk7(clk7), .reset_n(reset_n),
    .req_valid(r2_valid), .req_ready(r2_ready), .req_chip(r2_chip),
    .req_write(r2_write), .req_reg(r2_reg), .req_data(r2_data),
    .rsp_valid(r2_rsp_valid), .rsp_data(r2_rsp_data),
    .bdir(r2_bdir), .bc1(r2_bc1), .bus_dout(r2_dout),
    .bus_din(8'h00), .bus_oe_n(1'b1), .busy(r2_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] dout;
  } ph_t;

  ph_t        exp_q[$];
  logic [7:0] rsp_q[$];
  logic       m_chip = 1'b1;

  task automatic send(input logic chip, input logic write, input logic [3:0] r, input logic [7:0] d);
    int unsigned waited = 0;
    if (chip != m_chip) begin
      exp_q.push_back({2'b11, 7'h7F, chip});
      m_chip = chip;
    end
    exp_q.push_back({2'b11, 4'h0, r});
    if (write) exp_q.push_back({2'b10, d});
    else begin
      exp_q.push_back({2'b01, 4'h0, r});
      rsp_q.push_back(psg_oe_dis ? 8'hFF : 8'hA5);
    end
    @(negedge clk7);
    req_valid = 1'b1;
    req_chip  = chip;
    req_write = write;
    req_reg   = r;
    req_data  = d;
    while (!req_ready && waited < 200) begin
      @(negedge clk7);
      waited++;
    end
    chk("req_accept", req_ready, 1);
    @(posedge clk7);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned n = 0;
    @(negedge clk7);
    while (busy && n < limit) begin
      @(negedge clk7);
      n++;
    end
    chk("idle_timeout", busy, 0);
    repeat (2) @(negedge clk7);
  endtask

  // Monitor: each maximal run of an active phase is one bus transfer
  logic [1:0]  run_ph = '0;
  logic [7:0]  run_dout = '0;
  int unsigned run_len = 0;
  bit          in_run = 0;
  bit          rsp_prev = 0;
  ph_t         e;

  always @(negedge clk7) begin
    if (!reset_n) begin
      in_run   = 0;
      run_len  = 0;
      rsp_prev = 0;
    end else begin
      if (in_run && ({bdir, bc1} != run_ph || bus_dout != run_dout)) begin
        if (exp_q.size() == 0) chk("phase_unexpected", {run_ph, run_dout}, 0);
        else begin
          e = exp_q.pop_front();
          chk("phase_code", run_ph, e.ph);
          chk("phase_dout", run_dout, e.dout);
          chk("phase_len", run_len, 4);
        end
        in_run = 0;
      end
      if (in_run) run_len++;
      else if ({bdir, bc1} != 2'b00) begin
        in_run   = 1;
        run_ph   = {bdir, bc1};
        run_dout = bus_dout;
        run_len  = 1;
      end
      if (rsp_valid) begin
        chk("rsp_pulse_width", rsp_prev, 0);
        if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else chk("rsp_data", rsp_data, rsp_q.pop_front());
      end
      rsp_prev = rsp_valid;
    end
  end

  logic [1:0] t1_ph   [12] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
  logic       t1_busy [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [1:0] t2_ph   [8]  = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
  logic       t2_busy [8]  = '{1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    // Reset state
    repeat (3) @(negedge clk7);
    chk("rst_bdir", bdir, 0);
    chk("rst_bc1", bc1, 0);
    chk("rst_dout", bus_dout, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk7);
    chk("rst_ready", req_ready, 1);

    // Same-chip write: cycle-accurate timeline from the pop cycle
    send(1'b1, 1'b1, 4'd7, 8'h38);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk7);
      chk("t1_phase", {bdir, bc1}, t1_ph[i]);
      chk("t1_busy", busy, t1_busy[i]);
    end
    wait_idle(100);

    // Chip changes: select to chip0, stay, then back to chip1
    send(1'b0, 1'b1, 4'd0, 8'h55);
    send(1'b0, 1'b1, 4'd2, 8'h11);
    send(1'b1, 1'b1, 4'd1, 8'h22);
    wait_idle(200);

    // Reads with PSG output enabled, then disabled
    send(1'b1, 1'b0, 4'd14, 8'h00);
    wait_idle(100);
    psg_oe_dis = 1'b1;
    send(1'b1, 1'b0, 4'd14, 8'h00);
    wait_idle(100);
    chk("rsp_data_held", rsp_data, 8'hFF);
    psg_oe_dis = 1'b0;

    // Five back-to-back requests into a depth-4 queue
    send(1'b1, 1'b1, 4'd3, 8'h01);
    send(1'b0, 1'b1, 4'd4, 8'h02);
    send(1'b0, 1'b0, 4'd5, 8'h00);
    send(1'b1, 1'b1, 4'd6, 8'h04);
    chk("burst_ready_after4", req_ready, 1);
    send(1'b1, 1'b0, 4'd8, 8'h00);
    chk("burst_ready_after5", req_ready, 0);
    wait_idle(400);

    // Reset during the write-data phase of a chip0 write with one more queued
    send(1'b0, 1'b1, 4'd9, 8'h77);
    send(1'b1, 1'b1, 4'd10, 8'h66);
    begin
      int unsigned n = 0;
      @(negedge clk7);
      while (!(bdir && !bc1) && n < 100) begin
        @(negedge clk7);
        n++;
      end
      chk("abort_reach_data", {bdir, bc1}, 2'b10);
    end
    @(negedge clk7);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_bdir", bdir, 0);
    chk("abort_bc1", bc1, 0);
    chk("abort_dout", bus_dout, 8'h00);
    chk("abort_rsp_data", rsp_data, 8'h00);
    chk("abort_pending", exp_q.size(), 4);
    exp_q.delete();
    m_chip = 1'b1;
    repeat (2) @(negedge clk7);
    reset_n = 1'b1;
    repeat (3) @(negedge clk7);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_quiet", {bdir, bc1}, 2'b00);
    send(1'b1, 1'b1, 4'd11, 8'h5A);
    wait_idle(100);

    // HOLD_CYCLES=1, GAP_CYCLES=2 instance
    @(negedge clk7);
    r2_valid = 1'b1;
    r2_chip  = 1'b1;
    r2_write = 1'b1;
    r2_reg   = 4'd3;
    r2_data  = 8'h9C;
    chk("d2_ready", r2_ready, 1);
    @(posedge clk7);
    #1 r2_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk7);
      chk("d2_phase", {r2_bdir, r2_bc1}, t2_ph[i]);
      chk("d2_busy", r2_busy, t2_busy[i]);
      if (i == 1) chk("d2_addr", r2_dout, 8'h03);
      if (i == 4) chk("d2_data", r2_dout, 8'h9C);
    end

    repeat (3) @(negedge clk7);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("rsp_drained", rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
